// File: rtl/imm_pkg.sv
// Shared definitions for the RISC-V immediate generator: format codes, base
// opcodes and the rule for which formats produce a pc-relative target.
package imm_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Branches, JAL and AUIPC are the only instructions whose target is pc+imm;
  // JALR is I-type and its target depends on rs1, so it keeps pc.
  function automatic logic uses_pc_add(input fmt_e fmt, input logic [6:0] opcode);
    return (fmt == FMT_B) || (fmt == FMT_J) || (opcode == OP_AUIPC);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decode: raw instruction word -> sign-extended
// immediate, format code and illegal-opcode flag.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [6:0]  opcode;
  logic [31:0] imm32;

  assign opcode = inst[6:0];

  always_comb begin
    imm32   = '0;
    fmt     = FMT_R;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        fmt   = FMT_I;
        imm32 = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        fmt   = FMT_S;
        imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        fmt   = FMT_B;
        imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt   = FMT_U;
        imm32 = {inst[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt   = FMT_J;
        imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_REG: begin
        fmt   = FMT_R;
        imm32 = '0;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  // Every format's bit 31 is inst[31] (or zero), so widening from imm32 also
  // sign-extends U-type immediates on RV64.
  always_comb begin
    imm        = {XLEN{imm32[31]}};
    imm[31:0]  = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator for the decode stage: decode + pc adder in
// front of a two-entry (main + skid) buffer so in_ready comes from a flop.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [PC_W-1:0] out_target,
  output logic [PC_W-1:0] out_pc,
  output logic            out_illegal
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            illegal;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  fmt_e            dec_fmt;
  logic            dec_illegal;
  logic [PC_W-1:0] dec_target;
  entry_t          new_entry;

  entry_t m_q, k_q;
  logic   m_valid, k_valid, in_ready_q;
  logic   m_valid_nxt, k_valid_nxt;
  logic   m_load_new, m_load_k, k_load;
  logic   accept, transfer;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .inst    (in_inst),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Target arithmetic is modulo 2^PC_W; overflow wraps silently.
  always_comb begin
    dec_target = in_pc;
    if (uses_pc_add(dec_fmt, in_inst[6:0])) begin
      dec_target = in_pc + dec_imm[PC_W-1:0];
    end
  end

  always_comb begin
    new_entry.imm     = dec_imm;
    new_entry.fmt     = dec_fmt;
    new_entry.illegal = dec_illegal;
    new_entry.target  = dec_target;
    new_entry.pc      = in_pc;
  end

  // Handshake: a beat moves on a rising edge where valid and ready are both
  // high; valid never depends on ready, and in_ready is a flop equal to "skid
  // slot empty", so the producer never sees a combinational path from out_ready.
  assign accept   = in_valid & in_ready_q;
  assign transfer = m_valid & out_ready;

  // K only fills while M is stalled, so it can never hold an entry with M empty.
  always_comb begin
    m_valid_nxt = m_valid;
    k_valid_nxt = k_valid;
    m_load_new  = 1'b0;
    m_load_k    = 1'b0;
    k_load      = 1'b0;
    if (!m_valid) begin
      if (accept) begin
        m_load_new  = 1'b1;
        m_valid_nxt = 1'b1;
      end
    end else if (transfer) begin
      if (k_valid) begin
        m_load_k    = 1'b1;
        k_valid_nxt = 1'b0;
      end else if (accept) begin
        m_load_new  = 1'b1;
      end else begin
        m_valid_nxt = 1'b0;
      end
    end else if (accept) begin
      k_load      = 1'b1;
      k_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      m_valid    <= 1'b0;
      k_valid    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid    <= m_valid_nxt;
      k_valid    <= k_valid_nxt;
      in_ready_q <= !k_valid_nxt;
    end
  end

  // Payload registers only change on a load, which keeps out_* steady under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_q <= '0;
      k_q <= '0;
    end else if (!flush) begin
      if (m_load_new) begin
        m_q <= new_entry;
      end else if (m_load_k) begin
        m_q <= k_q;
      end
      if (k_load) begin
        k_q <= new_entry;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = m_valid;
  assign out_imm     = m_q.imm;
  assign out_fmt     = m_q.fmt;
  assign out_illegal = m_q.illegal;
  assign out_target  = m_q.target;
  assign out_pc      = m_q.pc;

endmodule
